// File: rtl/reorder_frame_packer.sv
// reorder_frame_packer
// Packs RATIO consecutive DW-bit words from the ordered reorder stream into
// one DW*RATIO-bit beat. The first word of a beat sits in the least
// significant lane. The final beat of each 2^AW-word frame is flagged with
// pk_if3_last.
// Optional build macro PK_FRAME_CNT_EN adds a 16-bit count of completed
// frames (pk_frame_cnt), which advances on each drained last beat.
module reorder_frame_packer #(
    parameter int DW    = 32,
    parameter int AW    = 10,
    parameter int RATIO = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DW-1:0]       if2_pk_data,
    input  logic                if2_pk_vld,
    output logic                pk_if2_rdy,
    output logic [DW*RATIO-1:0] pk_if3_data,
    output logic                pk_if3_last,
    output logic                pk_if3_vld,
    input  logic                if3_pk_rdy
`ifdef PK_FRAME_CNT_EN
    ,
    output logic [15:0]         pk_frame_cnt
`endif
);

    // Lane and beat counters keep at least one bit so that the degenerate
    // cases (RATIO=1, or one beat per frame) still elaborate. In those cases
    // the counter simply stays at zero.
    localparam int LG    = $clog2(RATIO);
    localparam int LCW   = (LG > 0) ? LG : 1;
    localparam int BEATS = (1 << AW) / RATIO;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [LCW-1:0] LANE_TOP = LCW'(RATIO - 1);
    localparam logic [BCW-1:0] BEAT_TOP = BCW'(BEATS - 1);

    logic [LCW-1:0]       lane_cnt_reg;
    logic [BCW-1:0]       beat_cnt_reg;
    logic [DW*RATIO-1:0]  acc_reg;
    logic [DW*RATIO-1:0]  acc_next;
    logic                 or_free;
    logic                 lane_full;
    logic                 in_xfer;
    logic                 beat_done;

    assign or_free    = !pk_if3_vld || if3_pk_rdy;
    assign lane_full  = (lane_cnt_reg == LANE_TOP);
    // Stall only when a completing word would overwrite an undrained beat.
    assign pk_if2_rdy = !lane_full || or_free;
    assign in_xfer    = if2_pk_vld && pk_if2_rdy;
    assign beat_done  = in_xfer && lane_full;

    // Accumulator image with the incoming word merged into its lane. It feeds
    // both the accumulator register and, on completion, the output beat, so
    // the top lane never has to be stored before it is emitted.
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            assign acc_next[gi*DW +: DW] =
                (in_xfer && (lane_cnt_reg == LCW'(gi))) ? if2_pk_data
                                                        : acc_reg[gi*DW +: DW];
        end
    endgenerate

    // Lane position inside the current beat; wraps after the top lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lane_cnt_reg <= '0;
        else if (in_xfer)
            lane_cnt_reg <= lane_full ? '0 : lane_cnt_reg + 1'b1;
    end

    // Beat position inside the frame; wraps after the frame's last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            beat_cnt_reg <= '0;
        else if (beat_done)
            beat_cnt_reg <= (beat_cnt_reg == BEAT_TOP) ? '0 : beat_cnt_reg + 1'b1;
    end

    // Partial-beat accumulator; stale lanes are overwritten before reuse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_reg <= '0;
        else
            acc_reg <= acc_next;
    end

    // Output register: reloads on completion (even while draining) and
    // otherwise clears its valid once the beat is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_if3_vld  <= 1'b0;
            pk_if3_last <= 1'b0;
            pk_if3_data <= '0;
        end else if (beat_done) begin
            pk_if3_vld  <= 1'b1;
            pk_if3_last <= (beat_cnt_reg == BEAT_TOP);
            pk_if3_data <= acc_next;
        end else if (if3_pk_rdy) begin
            pk_if3_vld  <= 1'b0;
        end
    end

`ifdef PK_FRAME_CNT_EN
    // Completed-frame counter, advanced by each drained last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pk_frame_cnt <= '0;
        else if (pk_if3_vld && if3_pk_rdy && pk_if3_last)
            pk_frame_cnt <= pk_frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_reorder_frame_packer.sv
// Testbench for reorder_frame_packer (DW=8, AW=3, RATIO=4 plus a RATIO=1
// instance). Expected beats come from a queue-based packing model.
module tb_reorder_frame_packer;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int RATIO = 4;
    localparam int FRAME = 1 << AW;
    localparam int BEATS = FRAME / RATIO;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]       in_data = '0;
    logic                in_vld = 1'b0;
    logic                in_rdy;
    logic [DW*RATIO-1:0] out_data;
    logic                out_last;
    logic                out_vld;
    logic                out_rdy = 1'b0;

    logic [DW-1:0]       r1_in_data = '0;
    logic                r1_in_vld = 1'b0;
    logic                r1_in_rdy;
    logic [DW-1:0]       r1_out_data;
    logic                r1_out_last;
    logic                r1_out_vld;
    logic                r1_out_rdy = 1'b1;

`ifdef PK_FRAME_CNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] r1_frame_cnt;
`endif

    reorder_frame_packer #(.DW(DW), .AW(AW), .RATIO(RATIO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if2_pk_data (in_data),
        .if2_pk_vld  (in_vld),
        .pk_if2_rdy  (in_rdy),
        .pk_if3_data (out_data),
        .pk_if3_last (out_last),
        .pk_if3_vld  (out_vld),
        .if3_pk_rdy  (out_rdy)
`ifdef PK_FRAME_CNT_EN
        ,
        .pk_frame_cnt(frame_cnt)
`endif
    );

    reorder_frame_packer #(.DW(DW), .AW(AW), .RATIO(1)) dut_r1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .if2_pk_data (r1_in_data),
        .if2_pk_vld  (r1_in_vld),
        .pk_if2_rdy  (r1_in_rdy),
        .pk_if3_data (r1_out_data),
        .pk_if3_last (r1_out_last),
        .pk_if3_vld  (r1_out_vld),
        .if3_pk_rdy  (r1_out_rdy)
`ifdef PK_FRAME_CNT_EN
        ,
        .pk_frame_cnt(r1_frame_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: words of the beat being built, and completed beats
    // waiting to be drained.
    typedef struct packed {
        logic                last;
        logic [DW*RATIO-1:0] data;
    } beat_t;

    logic [DW-1:0] part_q[$];
    beat_t         exp_q[$];
    int            beat_idx = 0;
    int            exp_frames = 0;

    task automatic model_reset();
        part_q.delete();
        exp_q.delete();
        beat_idx   = 0;
        exp_frames = 0;
    endtask

    task automatic model_push(input logic [DW-1:0] w);
        beat_t b;
        part_q.push_back(w);
        if (part_q.size() == RATIO) begin
            for (int i = 0; i < RATIO; i++)
                b.data[i*DW +: DW] = part_q[i];
            b.last = ((beat_idx % BEATS) == BEATS - 1);
            beat_idx++;
            exp_q.push_back(b);
            part_q.delete();
        end
    endtask

    // One clock of the main DUT: drive, check outputs against the model,
    // then advance the model by whatever transfers happen at the edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                        output logic acc);
        logic  exp_vld;
        logic  exp_rdy;
        logic  drain;
        beat_t f;
        @(negedge clk);
        in_vld  = v;
        in_data = d;
        out_rdy = r;
        #1;
        exp_vld = (exp_q.size() != 0);
        exp_rdy = (part_q.size() != RATIO - 1) || !exp_vld || r;
        n_cmp++;
        if (out_vld !== exp_vld) begin
            n_err++;
            $display("FAIL out_vld: got %b want %b", out_vld, exp_vld);
        end
        n_cmp++;
        if (in_rdy !== exp_rdy) begin
            n_err++;
            $display("FAIL in_rdy: got %b want %b", in_rdy, exp_rdy);
        end
        if (exp_vld && out_vld) begin
            f = exp_q[0];
            n_cmp++;
            if ({out_last, out_data} !== f) begin
                n_err++;
                $display("FAIL beat: got last=%b data=%h want last=%b data=%h",
                         out_last, out_data, f.last, f.data);
            end
        end
`ifdef PK_FRAME_CNT_EN
        n_cmp++;
        if (frame_cnt !== exp_frames[15:0]) begin
            n_err++;
            $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, exp_frames);
        end
`endif
        acc   = v && in_rdy;
        drain = out_vld && r;
        if (drain)
            $display("beat out: data=%h last=%b", out_data, out_last);
        @(posedge clk);
        if (drain && exp_vld) begin
            if (exp_q[0].last)
                exp_frames++;
            void'(exp_q.pop_front());
        end
        if (acc)
            model_push(d);
    endtask

    // mode 0: vld=1, rdy=1; mode 2: random vld and rdy with random data.
    task automatic send_words(input logic [DW-1:0] first, input int n, input int mode);
        logic          acc;
        logic          v;
        logic          r;
        logic [DW-1:0] w;
        int            budget;
        for (int i = 0; i < n; i++) begin
            w      = (mode == 2) ? DW'($urandom) : first + DW'(i);
            acc    = 1'b0;
            budget = 200;
            while (!acc && budget > 0) begin
                v = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
                r = (mode == 2) ? $urandom_range(0, 1) : 1'b1;
                step(v, w, r, acc);
                budget--;
            end
            if (!acc) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: got word %h not accepted want accepted", w);
            end
        end
    endtask

    task automatic drain_all();
        logic acc;
        int   budget;
        budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            step(1'b0, '0, 1'b1, acc);
            budget--;
        end
        step(1'b0, '0, 1'b1, acc);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d beats left want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({out_vld, out_last, out_data} !== '0) begin
            n_err++;
            $display("FAIL reset_out: got vld=%b last=%b data=%h want all 0",
                     out_vld, out_last, out_data);
        end
        n_cmp++;
        if (in_rdy !== 1'b1 || r1_in_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rdy: got %b/%b want 1/1", in_rdy, r1_in_rdy);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        send_words(8'h01, 8, 0);
        drain_all();
    endtask

    task automatic test_stall();
        logic acc;
        for (int w = 1; w <= 7; w++)
            step(1'b1, DW'(w), 1'b0, acc);
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 8'h08, 1'b0, acc);
            n_cmp++;
            if (acc !== 1'b0) begin
                n_err++;
                $display("FAIL stall_accept: got %b want 0", acc);
            end
        end
        step(1'b1, 8'h08, 1'b1, acc);
        n_cmp++;
        if (acc !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: got %b want 1", acc);
        end
        drain_all();
    endtask

    task automatic test_back_to_back();
        int f0;
        f0 = exp_frames;
        send_words(8'h00, 24, 0);
        drain_all();
        n_cmp++;
        if (exp_frames - f0 != 3) begin
            n_err++;
            $display("FAIL b2b_frames: got %0d want 3", exp_frames - f0);
        end
    endtask

    task automatic test_random();
        send_words('0, 1000, 2);
        drain_all();
    endtask

    task automatic test_reset_mid();
        logic acc;
        for (int w = 1; w <= 6; w++)
            step(1'b1, DW'(w), 1'b0, acc);
        @(negedge clk);
        in_vld = 1'b0;
        rst_n  = 1'b0;
        #1;
        n_cmp++;
        if ({out_vld, out_last, out_data} !== '0) begin
            n_err++;
            $display("FAIL midreset_out: got vld=%b last=%b data=%h want all 0",
                     out_vld, out_last, out_data);
        end
`ifdef PK_FRAME_CNT_EN
        n_cmp++;
        if (frame_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL midreset_frame_cnt: got %0d want 0", frame_cnt);
        end
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send_words(8'h11, 8, 0);
        drain_all();
    endtask

    task automatic test_ratio1();
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            r1_in_vld  = (i < 8);
            r1_in_data = 8'hA0 + DW'(i);
            r1_out_rdy = 1'b1;
            #1;
            if (i < 8) begin
                n_cmp++;
                if (r1_in_rdy !== 1'b1) begin
                    n_err++;
                    $display("FAIL r1_rdy: got %b want 1", r1_in_rdy);
                end
            end
            if (i > 0) begin
                n_cmp++;
                if (r1_out_vld !== 1'b1 || r1_out_data !== 8'hA0 + DW'(i - 1) ||
                    r1_out_last !== (i == 8)) begin
                    n_err++;
                    $display("FAIL r1_beat: got vld=%b data=%h last=%b want vld=1 data=%h last=%b",
                             r1_out_vld, r1_out_data, r1_out_last, 8'hA0 + DW'(i - 1), (i == 8));
                end
                $display("r1 beat out: data=%h last=%b", r1_out_data, r1_out_last);
            end
        end
        @(negedge clk);
        r1_in_vld = 1'b0;
        #1;
        n_cmp++;
        if (r1_out_vld !== 1'b0) begin
            n_err++;
            $display("FAIL r1_idle: got vld=%b want 0", r1_out_vld);
        end
`ifdef PK_FRAME_CNT_EN
        n_cmp++;
        if (r1_frame_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL r1_frame_cnt: got %0d want 1", r1_frame_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_ratio1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
